l2_l1_responder: RTL and testbench

Behavioural L2-side responder for the L1 data-cache miss interface. It accepts write-back and refill requests from the L1 data controller, waits a programmable latency, and then pulses the `ready_L2_L1` handshake for one cycle. It backs the requests with a small line store, so refilled data reflects earlier write-backs. It sits directly below the L1 data controller and serves as the L2 stand-in for the L1 cache bring-up and regression.

---
 rtl/l2_l1_responder.sv | 168 ++++++++++++++++
 tb/tb_l2_l1_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_l1_responder.sv
// L2-side responder for the L1 data-cache miss interface: latency-modelled
// refill/write-back handshake backed by a small line store. Optional macro: L2_RESP_MISS_EN.
module l2_l1_responder #(
    parameter int unsigned LINE_BITS      = 512,
    parameter int unsigned TAG_W          = 21,
    parameter int unsigned INDEX_W        = 5,
    parameter int unsigned STORE_TAG_BITS = 3,
    parameter int unsigned READ_LATENCY   = 4,
    parameter int unsigned WRITE_LATENCY  = 2,
    parameter int unsigned MISS_PENALTY   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 read_L1_L2,
    input  logic                 write_L1_L2,
    input  logic [INDEX_W-1:0]   index_L1_L2,
    input  logic [TAG_W-1:0]     tag_L1_L2,
    input  logic [TAG_W-1:0]     write_tag_L1_L2,
    input  logic [LINE_BITS-1:0] write_data_L1_L2,
    output logic                 ready_L2_L1,
    output logic [LINE_BITS-1:0] read_data_L2_L1,
    output logic                 busy
);

    localparam int unsigned ADDR_W   = STORE_TAG_BITS + INDEX_W;
    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam int unsigned FILL_W   = TAG_W + INDEX_W + 6;
    localparam int unsigned FILL_N   = LINE_BITS / FILL_W;
    localparam int unsigned LAT_RW   = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned LAT_MAX  = (LAT_RW > MISS_PENALTY) ? LAT_RW : MISS_PENALTY;
    localparam int unsigned CNT_W    = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
`ifdef L2_RESP_MISS_EN
    localparam int unsigned WTAG_W   = TAG_W;
`else
    localparam int unsigned WTAG_W   = STORE_TAG_BITS;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_WAIT = 3'd1,
        WB_DONE = 3'd2,
        RD_WAIT = 3'd3,
`ifdef L2_RESP_MISS_EN
        RD_PEN  = 3'd4,
`endif
        RD_DONE = 3'd5,
        RELEASE = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ready_d, busy_d, load_rd;

    logic [INDEX_W-1:0]    idx_q;
    logic [TAG_W-1:0]      tag_q;
    logic [WTAG_W-1:0]     wtag_q;
    logic [LINE_BITS-1:0]  wdata_q;

    logic [DEPTH-1:0]      valid_q;
    logic [LINE_BITS-1:0]  store_q [DEPTH];
    logic [ADDR_W-1:0]     waddr, raddr;
    logic                  rd_miss;
    logic [LINE_BITS-1:0]  fill_line;

    assign waddr = {wtag_q[STORE_TAG_BITS-1:0], idx_q};
    assign raddr = {tag_q[STORE_TAG_BITS-1:0], idx_q};

`ifdef L2_RESP_MISS_EN
    logic [TAG_W-1:0]      tag_mem_q [DEPTH];
    assign rd_miss = !valid_q[raddr] || (tag_mem_q[raddr] != tag_q);
`else
    logic                  unused_wtag_hi;
    assign unused_wtag_hi = ^write_tag_L1_L2[TAG_W-1:STORE_TAG_BITS];
    assign rd_miss = !valid_q[raddr];
`endif

    // Fill pattern: the line's byte address replicated across the line.
    always_comb begin
        fill_line = '0;
        for (int i = 0; i < int'(FILL_N); i++) begin
            fill_line[i*FILL_W +: FILL_W] = {tag_q, idx_q, 6'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (write_L1_L2) begin
                    state_d = WB_WAIT;
                    cnt_d   = CNT_W'(WRITE_LATENCY - 1);
                end else if (read_L1_L2) begin
                    state_d = RD_WAIT;
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                end
            end
            WB_WAIT: begin
                if (cnt_q == '0) state_d = WB_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            WB_DONE: state_d = RELEASE;
            RD_WAIT: begin
                if (cnt_q == '0) begin
`ifdef L2_RESP_MISS_EN
                    if (rd_miss) begin
                        state_d = RD_PEN;
                        cnt_d   = CNT_W'(MISS_PENALTY - 1);
                    end else begin
                        state_d = RD_DONE;
                    end
`else
                    state_d = RD_DONE;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef L2_RESP_MISS_EN
            RD_PEN: begin
                if (cnt_q == '0) state_d = RD_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
`endif
            RD_DONE: state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == WB_DONE) || (state_d == RD_DONE);
        busy_d  = (state_q != IDLE) && (state_d != IDLE);
        load_rd = (state_d == RD_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            ready_L2_L1     <= 1'b0;
            busy            <= 1'b0;
            read_data_L2_L1 <= '0;
            valid_q         <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_L2_L1 <= ready_d;
            busy        <= busy_d;
            if (load_rd) read_data_L2_L1 <= rd_miss ? fill_line : store_q[raddr];
            if (state_q == WB_DONE) valid_q[waddr] <= 1'b1;
        end
    end

    // Request capture and line store: data arrays carry no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE) begin
            idx_q   <= index_L1_L2;
            tag_q   <= tag_L1_L2;
            wtag_q  <= write_tag_L1_L2[WTAG_W-1:0];
            wdata_q <= write_data_L1_L2;
        end
        if (!rst && state_q == WB_DONE) begin
            store_q[waddr] <= wdata_q;
`ifdef L2_RESP_MISS_EN
            tag_mem_q[waddr] <= wtag_q;
`endif
        end
    end

endmodule

// File: tb/tb_l2_l1_responder.sv
// Scoreboard bench for l2_l1_responder: expected ready cycle and refill data
// come from a small line-store model of the responder.
module tb_l2_l1_responder;

    localparam int unsigned LB  = 512;
    localparam int unsigned TW  = 21;
    localparam int unsigned IW  = 5;
    localparam int unsigned STB = 3;
    localparam int unsigned RL  = 4;
    localparam int unsigned WL  = 2;
    localparam int unsigned MP  = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          read_L1_L2, write_L1_L2;
    logic [IW-1:0] index_L1_L2;
    logic [TW-1:0] tag_L1_L2, write_tag_L1_L2;
    logic [LB-1:0] write_data_L1_L2;
    logic          ready_L2_L1;
    logic [LB-1:0] read_data_L2_L1;
    logic          busy;

    l2_l1_responder dut (
        .clk              (clk),
        .rst              (rst),
        .read_L1_L2       (read_L1_L2),
        .write_L1_L2      (write_L1_L2),
        .index_L1_L2      (index_L1_L2),
        .tag_L1_L2        (tag_L1_L2),
        .write_tag_L1_L2  (write_tag_L1_L2),
        .write_data_L1_L2 (write_data_L1_L2),
        .ready_L2_L1      (ready_L2_L1),
        .read_data_L2_L1  (read_data_L2_L1),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned   cyc;
        logic [LB-1:0] data;
        bit            rd;
        logic [7:0]    addr;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [LB-1:0] m_data [256];
    bit            m_val  [256];
    logic [TW-1:0] m_tag  [256];

    function automatic logic [LB-1:0] fill(input logic [TW-1:0] t, input logic [IW-1:0] i);
        logic [31:0]   w;
        logic [LB-1:0] f;
        w = {t, i, 6'b0};
        for (int k = 0; k < 16; k++) f[k*32 +: 32] = w;
        return f;
    endfunction

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] f;
        for (int k = 0; k < 16; k++) f[k*32 +: 32] = $urandom;
        return f;
    endfunction

    function automatic void model_read(input logic [TW-1:0] t, input logic [IW-1:0] i,
                                       output logic [LB-1:0] d, output int unsigned lat);
        logic [7:0] a;
        bit         miss;
        a = {t[STB-1:0], i};
`ifdef L2_RESP_MISS_EN
        miss = !m_val[a] || (m_tag[a] != t);
        lat  = miss ? RL + MP : RL;
`else
        miss = !m_val[a];
        lat  = RL;
`endif
        d = miss ? fill(t, i) : m_data[a];
    endfunction

    task automatic issue_read(input logic [TW-1:0] t, input logic [IW-1:0] i);
        exp_t        e;
        int unsigned lat;
        read_L1_L2  = 1'b1;
        tag_L1_L2   = t;
        index_L1_L2 = i;
        model_read(t, i, e.data, lat);
        e.rd  = 1'b1;
        e.cyc = cyc + 1 + lat;
        e.addr = '0;
        e.tag  = t;
        sb.push_back(e);
    endtask

    task automatic issue_write(input logic [TW-1:0] t, input logic [IW-1:0] i, input logic [LB-1:0] d);
        exp_t e;
        write_L1_L2      = 1'b1;
        write_tag_L1_L2  = t;
        index_L1_L2      = i;
        write_data_L1_L2 = d;
        e.rd   = 1'b0;
        e.cyc  = cyc + 1 + WL;
        e.data = d;
        e.addr = {t[STB-1:0], i};
        e.tag  = t;
        sb.push_back(e);
    endtask

    // Waits for the next ready pulse (bounded) and pops the matching expectation.
    task automatic await_ready(output exp_t e, output bit seen, output int unsigned at,
                               output int unsigned busy_n);
        busy_n = 0;
        seen   = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (ready_L2_L1 === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        at = cyc;
        e  = sb.pop_front();
        if (seen && !e.rd) begin
            m_val[e.addr]  = 1'b1;
            m_data[e.addr] = e.data;
            m_tag[e.addr]  = e.tag;
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 20 && busy !== 1'b0; n++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        read_L1_L2 = 1'b0; write_L1_L2 = 1'b0;
        index_L1_L2 = '0; tag_L1_L2 = '0; write_tag_L1_L2 = '0; write_data_L1_L2 = '0;
        for (int k = 0; k < 256; k++) m_val[k] = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ready_L2_L1 !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready_L2_L1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (read_data_L2_L1 !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", read_data_L2_L1); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    logic [LB-1:0] last_rd;

    task automatic test_read_fill();
        exp_t e; bit seen; int unsigned at, bn;
        logic [LB-1:0] lit;
        lit = {16{32'h000558C0}};
        issue_read(21'h000AB, 5'd3);
        await_ready(e, seen, at, bn);
        read_L1_L2 = 1'b0;
        checks++; if (!seen || at !== e.cyc) begin errors++; $display("FAIL fill_ready_cycle got %0d want %0d", at, e.cyc); end
        checks++; if (read_data_L2_L1 !== e.data) begin errors++; $display("FAIL fill_data got %h want %h", read_data_L2_L1, e.data); end
        checks++; if (read_data_L2_L1 !== lit) begin errors++; $display("FAIL fill_literal got %h want %h", read_data_L2_L1, lit); end
        last_rd = read_data_L2_L1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            bn++;
        end
        checks++; if (bn != 5) begin errors++; $display("FAIL busy_len got %0d want 5", bn); end
        wait_idle();
    endtask

    task automatic test_write_read();
        exp_t e; bit seen; int unsigned at, bn;
        issue_write(21'h000AB, 5'd3, {64{8'hA5}});
        await_ready(e, seen, at, bn);
        write_L1_L2 = 1'b0;
        checks++; if (!seen || at !== e.cyc) begin errors++; $display("FAIL wb_ready_cycle got %0d want %0d", at, e.cyc); end
        checks++; if (read_data_L2_L1 !== last_rd) begin errors++; $display("FAIL rdata_hold got %h want %h", read_data_L2_L1, last_rd); end
        wait_idle();
        issue_read(21'h000AB, 5'd3);
        await_ready(e, seen, at, bn);
        read_L1_L2 = 1'b0;
        checks++; if (!seen || at !== e.cyc) begin errors++; $display("FAIL wr_rd_ready_cycle got %0d want %0d", at, e.cyc); end
        checks++; if (read_data_L2_L1 !== e.data) begin errors++; $display("FAIL wr_rd_data got %h want %h", read_data_L2_L1, e.data); end
        wait_idle();
    endtask

    task automatic test_both();
        exp_t e, r; bit seen; int unsigned at, bn, lat, extra;
        read_L1_L2 = 1'b1;
        tag_L1_L2  = 21'h20;
        issue_write(21'h10, 5'd7, rand_line());
        await_ready(e, seen, at, bn);
        write_L1_L2 = 1'b0;
        checks++; if (!seen || at !== e.cyc) begin errors++; $display("FAIL both_wb_cycle got %0d want %0d", at, e.cyc); end
        model_read(21'h20, 5'd7, r.data, lat);
        r.rd = 1'b1; r.cyc = at + 3 + lat; r.addr = '0; r.tag = 21'h20;
        sb.push_back(r);
        await_ready(e, seen, at, bn);
        read_L1_L2 = 1'b0;
        checks++; if (!seen || at !== e.cyc) begin errors++; $display("FAIL both_rd_cycle got %0d want %0d", at, e.cyc); end
        checks++; if (read_data_L2_L1 !== e.data) begin errors++; $display("FAIL both_rd_data got %h want %h", read_data_L2_L1, e.data); end
        extra = 0;
        repeat (12) begin @(negedge clk); if (ready_L2_L1 === 1'b1) extra++; end
        checks++; if (extra != 0) begin errors++; $display("FAIL both_extra_pulses got %0d want 0", extra); end
    endtask

    task automatic test_hold();
        exp_t e, r; bit seen; int unsigned at, bn;
        issue_read(21'h00005, 5'd9);
        await_ready(e, seen, at, bn);
        checks++; if (!seen || at !== e.cyc) begin errors++; $display("FAIL hold_first_cycle got %0d want %0d", at, e.cyc); end
        checks++; if (read_data_L2_L1 !== e.data) begin errors++; $display("FAIL hold_first_data got %h want %h", read_data_L2_L1, e.data); end
        r = e;
        r.cyc = at + 3 + RL;
        sb.push_back(r);
        await_ready(e, seen, at, bn);
        read_L1_L2 = 1'b0;
        checks++; if (!seen || at !== e.cyc) begin errors++; $display("FAIL hold_second_cycle got %0d want %0d", at, e.cyc); end
        checks++; if (read_data_L2_L1 !== e.data) begin errors++; $display("FAIL hold_second_data got %h want %h", read_data_L2_L1, e.data); end
        wait_idle();
    endtask

    task automatic test_rst_mid();
        exp_t e; bit seen; int unsigned at, bn, pulses;
        issue_write(21'h33, 5'd12, rand_line());
        e = sb.pop_back();
        pulses = 0;
        repeat (2) begin @(negedge clk); if (ready_L2_L1 === 1'b1) pulses++; end
        rst = 1'b1;
        write_L1_L2 = 1'b0;
        @(negedge clk); if (ready_L2_L1 === 1'b1) pulses++;
        rst = 1'b0;
        for (int k = 0; k < 256; k++) m_val[k] = 1'b0;
        repeat (6) begin @(negedge clk); if (ready_L2_L1 === 1'b1) pulses++; end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_pulses got %0d want 0", pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        checks++; if (read_data_L2_L1 !== '0) begin errors++; $display("FAIL rst_mid_rdata got %h want 0", read_data_L2_L1); end
        issue_read(21'h33, 5'd12);
        await_ready(e, seen, at, bn);
        read_L1_L2 = 1'b0;
        checks++; if (!seen || at !== e.cyc) begin errors++; $display("FAIL rst_mid_rd_cycle got %0d want %0d", at, e.cyc); end
        checks++; if (read_data_L2_L1 !== e.data) begin errors++; $display("FAIL rst_mid_rd_data got %h want %h", read_data_L2_L1, e.data); end
        wait_idle();
    endtask

    task automatic test_alias();
        exp_t e; bit seen; int unsigned at, bn;
        issue_write(21'h08, 5'd1, rand_line());
        await_ready(e, seen, at, bn);
        write_L1_L2 = 1'b0;
        checks++; if (!seen || at !== e.cyc) begin errors++; $display("FAIL alias_wb_cycle got %0d want %0d", at, e.cyc); end
        wait_idle();
        issue_read(21'h10, 5'd1);
        await_ready(e, seen, at, bn);
        read_L1_L2 = 1'b0;
        checks++; if (!seen || at !== e.cyc) begin errors++; $display("FAIL alias_rd_cycle got %0d want %0d", at, e.cyc); end
        checks++; if (read_data_L2_L1 !== e.data) begin errors++; $display("FAIL alias_rd_data got %h want %h", read_data_L2_L1, e.data); end
        wait_idle();
    endtask

    initial begin
        last_rd = '0;
        test_reset();
        test_read_fill();
        test_write_read();
        test_both();
        test_hold();
        test_rst_mid();
        test_alias();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
